dmem_model: RTL and testbench
=============================

DMEM_MODEL -- requirements
Module: dmem_model

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 10, log2 of word count in the storage array.
REQ-002 SHALL have parameter LATENCY, default 4, clock edges from request acceptance to mem_ready; legal range 2..15.
REQ-003 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_read  input  1  read request, held by requester until mem_ready.
REQ-006 SHALL have port mem_write  input  1  write request, held by requester until mem_ready.
REQ-007 SHALL have port mem_addr  input  30  word address.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_rdata  output  32  read data, valid while mem_ready is high after a read.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion strobe.
REQ-011 SHALL have port snoop_addr  output  30  address of the last committed write, for the downstream pass checker.
REQ-012 SHALL have port snoop_data  output  32  data of the last committed write.
REQ-013 SHALL have port snoop_wen  output  1  one-cycle pulse marking a write commit.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE: on mem_read or mem_write high, SHALL latch addr, wdata and operation, then go to BUSY.
REQ-016 BUSY: SHALL count down a 4-bit counter; at terminal count SHALL go to DONE so that mem_ready is high exactly LATENCY edges after the accepting edge.
REQ-017 DONE: SHALL assert mem_ready for one cycle, then return to IDLE unconditionally.
REQ-018 Write: array write and snoop_wen pulse SHALL occur in the same cycle that mem_ready is high; snoop_addr/snoop_data SHALL update in that cycle and hold afterwards.
REQ-019 Read: mem_rdata SHALL present array[latched addr] while mem_ready is high; otherwise mem_rdata SHALL hold its last value.
REQ-020 mem_read and mem_write both high at acceptance SHALL be treated as a write only; mem_rdata unchanged.
REQ-021 Array index SHALL be mem_addr[DEPTH_LOG2-1:0]; upper bits ignored (address wrap-around, no error).
REQ-022 Request dropped (both mem_read and mem_write low) while in BUSY SHALL abort: return to IDLE next edge, no write, no mem_ready, no snoop_wen.
REQ-023 A request held high in the cycle after DONE SHALL be accepted as a new transaction; back-to-back transactions SHALL complete at the fixed rate of one per LATENCY+1 cycles.
REQ-024 Request inputs changing during BUSY other than a drop SHALL be ignored; latched values are used.

Reset
REQ-025 On rst low, SHALL force IDLE, counter 0, mem_ready 0, snoop_wen 0, mem_rdata 0, snoop_addr 0, snoop_data 0, immediately and independent of clk.
REQ-026 Reset mid-transaction SHALL discard it with no array write; array contents SHALL NOT be cleared by reset.

Configuration
REQ-027 Macro DMEM_STALL_EN defined: LATENCY-cycle behaviour per REQ-016.
REQ-028 DMEM_STALL_EN undefined: BUSY bypassed (IDLE->DONE), mem_ready exactly 1 edge after acceptance, LATENCY ignored; REQ-022 is not applicable.

Structure
REQ-029 Package dmem_pkg SHALL hold the state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10), data/address width constants (32, 30) and the default LATENCY.
REQ-030 Storage SHALL be a sub-module dmem_array (single-port synchronous-write, asynchronous-read, 2**DEPTH_LOG2 x 32).

Verification
REQ-031 Reset, then write addr 0, data 90, DMEM_STALL_EN, LATENCY 4 -> mem_ready and snoop_wen high together on the 4th edge after acceptance; snoop_addr=0, snoop_data=90.
REQ-032 Write addr 5 = 0xDEADBEEF, then read addr 5 -> mem_rdata=0xDEADBEEF while mem_ready is high.
REQ-033 Write addr 0x400 = 7 with DEPTH_LOG2 10, then read addr 0 -> 7 (wrap).
REQ-034 Write request dropped 2 cycles after acceptance -> no mem_ready, no snoop_wen; subsequent read of that address returns the old value.
REQ-035 mem_read and mem_write both high, addr 3, data 0x55 -> write committed, snoop_wen pulses, mem_rdata unchanged; rst low mid-BUSY -> all outputs 0 immediately, no write.
REQ-036 Build without DMEM_STALL_EN: held write -> mem_ready 1 edge after acceptance; 10 back-to-back writes complete in 20 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data-memory model.
//   DATA_W / ADDR_W  : data word and word-address widths.
//   DEFAULT_LATENCY  : default request-to-ready latency in clock edges.
//   state_t          : controller FSM encoding (IDLE, BUSY, DONE).
package dmem_pkg;

  localparam int DATA_W          = 32;
  localparam int ADDR_W          = 30;
  localparam int DEFAULT_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// dmem_array -- word storage for dmem_model.
// Single port: synchronous write on the rising clk edge, asynchronous read.
// Contents are never reset.
// Ports:
//   clk      in  clock
//   we_i     in  write enable
//   addr_i   in  word index [DEPTH_LOG2-1:0]
//   wdata_i  in  write data
//   rdata_o  out read data at addr_i (combinational)
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_model.sv
// dmem_model -- fixed-latency data memory with a write snoop port.
//
// Handshake: the requester raises mem_read and/or mem_write with mem_addr /
// mem_wdata and holds them until mem_ready. The request is accepted on the
// edge that finds the controller IDLE; mem_ready is a one-cycle strobe in
// the completion cycle. Both strobes high means write. Dropping both strobes
// while BUSY abandons the transaction.
//
// Build option: macro DMEM_STALL_EN defined -> mem_ready is high exactly
// LATENCY edges after acceptance (IDLE->BUSY->DONE). Undefined -> BUSY is
// skipped and mem_ready follows 1 edge after acceptance; LATENCY is ignored.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   mem_read    in   read request
//   mem_write   in   write request
//   mem_addr    in   word address (low DEPTH_LOG2 bits index the array)
//   mem_wdata   in   write data
//   mem_rdata   out  read data, valid while mem_ready after a read, else holds
//   mem_ready   out  one-cycle completion strobe
//   snoop_addr  out  address of last committed write
//   snoop_data  out  data of last committed write
//   snoop_wen   out  one-cycle pulse on write commit
module dmem_model
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] snoop_addr,
  output logic [DATA_W-1:0] snoop_data,
  output logic              snoop_wen
);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] snoop_addr_q;
  logic [DATA_W-1:0] snoop_data_q;

  logic              req;
  logic              done;
  logic              commit_wr;
  logic              read_done;
  logic [DATA_W-1:0] arr_rdata;

`ifdef DMEM_STALL_EN
  // BUSY lasts LATENCY-1 cycles: load LATENCY-2 and leave when it reaches 0.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);
`else
  logic unused_cfg;
  assign unused_cfg = ^{cnt_q, 4'(LATENCY)};
`endif

  assign req = mem_read | mem_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wr_d    = mem_write;
`ifdef DMEM_STALL_EN
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
`else
          state_d = DONE;
`endif
        end
      end
      BUSY: begin
`ifdef DMEM_STALL_EN
        if (!req) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
`else
        state_d = IDLE;
`endif
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign done      = (state_q == DONE);
  assign commit_wr = done & wr_q;
  assign read_done = done & ~wr_q;

  // Outputs present the new value during the completion cycle and the
  // registered copy afterwards, so they hold until the next completion.
  assign mem_ready  = done;
  assign snoop_wen  = commit_wr;
  assign mem_rdata  = read_done ? arr_rdata : rdata_q;
  assign snoop_addr = commit_wr ? addr_q : snoop_addr_q;
  assign snoop_data = commit_wr ? wdata_q : snoop_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      rdata_q      <= '0;
      snoop_addr_q <= '0;
      snoop_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wr_q         <= wr_d;
      rdata_q      <= mem_rdata;
      snoop_addr_q <= snoop_addr;
      snoop_data_q <= snoop_data;
    end
  end

  dmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk     (clk),
    .we_i    (commit_wr),
    .addr_i  (addr_q[DEPTH_LOG2-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

endmodule

// File: tb/tb_dmem_model.sv
// tb_dmem_model -- directed bench for dmem_model with a transaction-level
// model. Works for builds with or without DMEM_STALL_EN.
module tb_dmem_model;
  import dmem_pkg::*;

  localparam int DEPTH_LOG2 = 10;
  localparam int LATENCY    = 4;
`ifdef DMEM_STALL_EN
  localparam int EFF_LAT    = LATENCY;
  localparam int RST_AT     = 2;
  localparam int B2B_LAST   = 49;
`else
  localparam int EFF_LAT    = 1;
  localparam int RST_AT     = 1;
  localparam int B2B_LAST   = 19;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [DATA_W-1:0] mem_wdata = '0;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic [ADDR_W-1:0] snoop_addr;
  logic [DATA_W-1:0] snoop_data;
  logic              snoop_wen;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  dmem_model #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LATENCY    (LATENCY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .snoop_addr (snoop_addr),
    .snoop_data (snoop_data),
    .snoop_wen  (snoop_wen)
  );

  // ---------------- scoreboard / model ----------------
  typedef struct {
    int                done_cyc;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } txn_t;

  txn_t              exp_q[$];
  logic [DATA_W-1:0] model_mem [int];
  logic [DATA_W-1:0] exp_rdata = '0;
  logic [ADDR_W-1:0] exp_saddr = '0;
  logic [DATA_W-1:0] exp_sdata = '0;
  int                checks = 0;
  int                errors = 0;
  int                ready_cnt = 0;
  int                last_ready_cyc = 0;

  function automatic int idx(logic [ADDR_W-1:0] a);
    return int'(a) % (1 << DEPTH_LOG2);
  endfunction

  task automatic check(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  txn_t cur;
  bit   exp_ready;
  bit   exp_wen;

  always @(negedge clk) begin
    if (rst) begin
      exp_ready = 1'b0;
      exp_wen   = 1'b0;
      if (exp_q.size() != 0 && exp_q[0].done_cyc == cyc) begin
        cur       = exp_q.pop_front();
        exp_ready = 1'b1;
        if (cur.wr) begin
          exp_wen              = 1'b1;
          model_mem[idx(cur.addr)] = cur.data;
          exp_saddr            = cur.addr;
          exp_sdata            = cur.data;
        end else begin
          exp_rdata = model_mem[idx(cur.addr)];
        end
      end
      check("mem_ready",  32'(mem_ready),  32'(exp_ready));
      check("snoop_wen",  32'(snoop_wen),  32'(exp_wen));
      check("mem_rdata",  mem_rdata,       exp_rdata);
      check("snoop_addr", 32'(snoop_addr), 32'(exp_saddr));
      check("snoop_data", snoop_data,      exp_sdata);
      if (mem_ready) begin
        ready_cnt++;
        last_ready_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(bit rd, bit wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
  endtask

  task automatic drop();
    drive(1'b0, 1'b0, '0, '0);
  endtask

  // Issue one request just after an edge, hold it through completion and
  // return in the following IDLE cycle with the request still driven.
  task automatic txn(bit rd, bit wr, logic [ADDR_W-1:0] a, logic [DATA_W-1:0] d, bit scramble);
    txn_t t;
    int   left;
    drive(rd, wr, a, d);
    t.done_cyc = cyc + EFF_LAT;
    t.wr       = wr;
    t.addr     = a;
    t.data     = d;
    exp_q.push_back(t);
    left = EFF_LAT + 1;
    if (scramble && EFF_LAT > 1) begin
      step();
      drive(1'b1, 1'b1, ~a, ~d);
      left--;
    end
    repeat (left) step();
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_ready"}, 32'(mem_ready),  32'd0);
    check({tag, "_wen"},   32'(snoop_wen),  32'd0);
    check({tag, "_rdata"}, mem_rdata,       32'd0);
    check({tag, "_saddr"}, 32'(snoop_addr), 32'd0);
    check({tag, "_sdata"}, snoop_data,      32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #2;
    check_all_zero("reset");
    step();
    step();
    rst = 1'b1;
    step();

    // Write addr 0 = 90.
    txn(1'b0, 1'b1, 30'd0, 32'd90, 1'b0);
    drop();
    check("w0_saddr", 32'(snoop_addr), 32'd0);
    check("w0_sdata", snoop_data, 32'd90);
    check("w0_rdata", mem_rdata, 32'd0);

    // Write then read addr 5; inputs scrambled during BUSY on the read.
    txn(1'b0, 1'b1, 30'd5, 32'hDEADBEEF, 1'b0);
    txn(1'b1, 1'b0, 30'd5, 32'd0, 1'b1);
    drop();
    check("rd5_rdata", mem_rdata, 32'hDEADBEEF);

    // Address wrap: 0x400 aliases 0.
    txn(1'b0, 1'b1, 30'h400, 32'd7, 1'b0);
    txn(1'b1, 1'b0, 30'd0, 32'd0, 1'b0);
    drop();
    check("wrap_rdata", mem_rdata, 32'd7);

    // Read and write together is a write; mem_rdata untouched.
    txn(1'b1, 1'b1, 30'd3, 32'h55, 1'b0);
    drop();
    check("rw_rdata", mem_rdata, 32'd7);
    check("rw_saddr", 32'(snoop_addr), 32'd3);
    check("rw_sdata", snoop_data, 32'h55);
    txn(1'b1, 1'b0, 30'd3, 32'd0, 1'b0);
    drop();
    check("rd3_rdata", mem_rdata, 32'h55);

`ifdef DMEM_STALL_EN
    // Abort: write dropped 2 cycles after acceptance.
    drive(1'b0, 1'b1, 30'd3, 32'h99);
    ready_cnt = 0;
    step();
    step();
    drop();
    repeat (6) step();
    check("abort_ready_cnt", 32'(ready_cnt), 32'd0);
    txn(1'b1, 1'b0, 30'd3, 32'd0, 1'b0);
    drop();
    check("abort_rdata", mem_rdata, 32'h55);
`endif

    // Reset in the middle of a write.
    drive(1'b0, 1'b1, 30'd3, 32'hAA);
    repeat (RST_AT) step();
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    exp_rdata = '0;
    exp_saddr = '0;
    exp_sdata = '0;
    drop();
    step();
    rst = 1'b1;
    step();
    txn(1'b1, 1'b0, 30'd3, 32'd0, 1'b0);
    drop();
    check("midrst_rdata", mem_rdata, 32'h55);

    // Ten back-to-back writes at one per LATENCY+1 cycles.
    ready_cnt = 0;
    begin
      int start_c;
      start_c = cyc;
      for (int i = 0; i < 10; i++) begin
        txn(1'b0, 1'b1, 30'(16 + i), 32'(i * 3 + 1), 1'b0);
      end
      drop();
      check("b2b_ready_cnt", 32'(ready_cnt), 32'd10);
      check("b2b_last_ready", 32'(last_ready_cyc - start_c), 32'(B2B_LAST));
    end
    txn(1'b1, 1'b0, 30'd20, 32'd0, 1'b0);
    drop();
    check("b2b_rd20", mem_rdata, 32'd13);
    check("b2b_sdata", snoop_data, 32'd28);

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
